// File: rtl/tdm_demux_7bits_pkg.sv
// Shared definitions for the 7-bit TDM segment mux/demux pair.
//   DEFAULT_W        : default bus / channel word width
//   ST_IDLE, ST_GOT0 : frame-tracker state encodings
//   CH0, CH1         : values of the sel channel tag
package tdm_demux_7bits_pkg;

    localparam int unsigned DEFAULT_W = 7;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_GOT0 = 1'b1;

    typedef enum logic [0:0] {
        StIdle = ST_IDLE,
        StGot0 = ST_GOT0
    } state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/tdm_timeout_timer.sv
// Frame timeout counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to 0 (wins over en)
//   en         : advance by one; holds once TIMEOUT-1 is reached
//   tc         : count is TIMEOUT-1
module tdm_timeout_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;

    assign tc = (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + TW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux_7bits.sv
// Receive side of the 2:1 segment mux: steers each tagged bus word into a
// held per-channel register and tracks ch0->ch1 frame order.
//   clk, rst_n            : clock, synchronous active-low reset
//   bus_in, bus_valid     : shared data word and its qualifier
//   sel, sync             : channel tag (0=ch0) and frame-start marker
//   ch0_data, ch1_data    : last word seen on each channel
//   ch0_new, ch1_new      : pulse when the matching register updates
//   frame_done, seq_err   : pulse on completed frame / framing error
//   frame_cnt, err_cnt    : frame count (wraps), error count (saturates)
module tdm_demux_7bits
    import tdm_demux_7bits_pkg::*;
#(
    parameter int unsigned W       = DEFAULT_W,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     bus_in,
    input  logic             bus_valid,
    input  logic             sel,
    input  logic             sync,
    output logic [W-1:0]     ch0_data,
    output logic [W-1:0]     ch1_data,
    output logic             ch0_new,
    output logic             ch1_new,
    output logic             frame_done,
    output logic             seq_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_e state;
    logic   in_got0;
    logic   timer_tc;
    logic   timer_clr;
    logic   timer_en;
    logic   frame_evt;
    logic   err_evt;

    assign in_got0 = (state == StGot0);

    // Any word in GOT0 either restarts or leaves the frame, so the timer only
    // needs to run across idle cycles while waiting for ch1.
    assign timer_clr = !in_got0 || bus_valid;
    assign timer_en  = in_got0 && !bus_valid;

    tdm_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (timer_clr),
        .en   (timer_en),
        .tc   (timer_tc)
    );

    // A ch1 word always takes priority over the timeout, so a frame finishing
    // on the timeout cycle never also reports an error.
    always_comb begin
        frame_evt = 1'b0;
        err_evt   = 1'b0;
        unique case (state)
            StIdle: begin
                err_evt = bus_valid && (sel == CH1);
            end
            StGot0: begin
                if (bus_valid) begin
                    frame_evt = (sel == CH1);
                    err_evt   = (sel == CH0);
                end else begin
                    err_evt = timer_tc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            ch0_data   <= '0;
            ch1_data   <= '0;
            ch0_new    <= 1'b0;
            ch1_new    <= 1'b0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            // Steering ignores frame state entirely.
            ch0_new <= bus_valid && (sel == CH0);
            ch1_new <= bus_valid && (sel == CH1);
            if (bus_valid && (sel == CH0)) begin
                ch0_data <= bus_in;
            end
            if (bus_valid && (sel == CH1)) begin
                ch1_data <= bus_in;
            end

            frame_done <= frame_evt;
            seq_err    <= err_evt;

            unique case (state)
                StIdle: begin
                    if (bus_valid && (sel == CH0) && sync) begin
                        state <= StGot0;
                    end
                end
                StGot0: begin
                    // ch0+sync restarts the frame in place; everything else
                    // that ends the wait returns to IDLE.
                    if (bus_valid) begin
                        if ((sel == CH1) || !sync) begin
                            state <= StIdle;
                        end
                    end else if (timer_tc) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            if (frame_evt) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (err_evt && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_7bits.sv
// Directed bench for tdm_demux_7bits. A behavioural frame model predicts each
// cycle's outputs into a scoreboard queue; entries are popped and compared one
// cycle later. A second instance with CNT_W=2 shares the stimulus to exercise
// counter wrap and saturation.
module tb_tdm_demux_7bits;

    localparam int W       = 7;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_W2  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     bus_in;
    logic             bus_valid;
    logic             sel;
    logic             sync;

    logic [W-1:0]     ch0_data, ch1_data;
    logic             ch0_new, ch1_new, frame_done, seq_err;
    logic [CNT_W-1:0] frame_cnt, err_cnt;

    logic [W-1:0]      s_ch0_data, s_ch1_data;
    logic              s_ch0_new, s_ch1_new, s_frame_done, s_seq_err;
    logic [CNT_W2-1:0] s_frame_cnt, s_err_cnt;

    always #5 clk = ~clk;

    tdm_demux_7bits #(
        .W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_valid(bus_valid),
        .sel(sel), .sync(sync), .ch0_data(ch0_data), .ch1_data(ch1_data),
        .ch0_new(ch0_new), .ch1_new(ch1_new), .frame_done(frame_done),
        .seq_err(seq_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    tdm_demux_7bits #(
        .W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W2)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_valid(bus_valid),
        .sel(sel), .sync(sync), .ch0_data(s_ch0_data), .ch1_data(s_ch1_data),
        .ch0_new(s_ch0_new), .ch1_new(s_ch1_new), .frame_done(s_frame_done),
        .seq_err(s_seq_err), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
    );

    typedef struct {
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         n0;
        logic         n1;
        logic         fd;
        logic         se;
        int           frames;
        int           errs;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    // Reference frame model state
    bit           m_got0 = 1'b0;
    int           m_timer = 0;
    logic [W-1:0] m_d0 = '0;
    logic [W-1:0] m_d1 = '0;
    int           m_frames = 0;
    int           m_errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check("ch0_data",   32'(ch0_data),   32'(e.d0));
        check("ch1_data",   32'(ch1_data),   32'(e.d1));
        check("ch0_new",    32'(ch0_new),    32'(e.n0));
        check("ch1_new",    32'(ch1_new),    32'(e.n1));
        check("frame_done", 32'(frame_done), 32'(e.fd));
        check("seq_err",    32'(seq_err),    32'(e.se));
        check("frame_cnt",  32'(frame_cnt),  32'(e.frames % 256));
        check("err_cnt",    32'(err_cnt),    32'(sat(e.errs, 255)));
        check("small_frame_cnt", 32'(s_frame_cnt), 32'(e.frames % 4));
        check("small_err_cnt",   32'(s_err_cnt),   32'(sat(e.errs, 3)));
    endtask

    // Drive one cycle of inputs, predict the registered result, then check it.
    task automatic step(input logic r, input logic v, input logic s, input logic sy,
                        input logic [W-1:0] d);
        exp_t e;
        rst_n     = r;
        bus_valid = v;
        sel       = s;
        sync      = sy;
        bus_in    = d;
        e.n0 = 1'b0;
        e.n1 = 1'b0;
        e.fd = 1'b0;
        e.se = 1'b0;
        if (!r) begin
            m_got0 = 1'b0;
            m_timer = 0;
            m_d0 = '0;
            m_d1 = '0;
            m_frames = 0;
            m_errs = 0;
        end else begin
            if (v && !s) begin m_d0 = d; e.n0 = 1'b1; end
            if (v && s)  begin m_d1 = d; e.n1 = 1'b1; end
            if (!m_got0) begin
                if (v && s) e.se = 1'b1;
                else if (v && sy) begin m_got0 = 1'b1; m_timer = 0; end
            end else if (v) begin
                if (s) begin e.fd = 1'b1; m_got0 = 1'b0; end
                else begin
                    e.se = 1'b1;
                    if (sy) m_timer = 0;
                    else m_got0 = 1'b0;
                end
            end else if (m_timer == TIMEOUT - 1) begin
                e.se = 1'b1;
                m_got0 = 1'b0;
            end else begin
                m_timer++;
            end
            if (e.fd) m_frames++;
            if (e.se) m_errs++;
        end
        e.d0 = m_d0;
        e.d1 = m_d1;
        e.frames = m_frames;
        e.errs = m_errs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom), 1'($urandom), 7'($urandom));
    endtask

    initial begin
        // Reset with bus activity
        step(1'b0, 1'b1, 1'b0, 1'b1, 7'h3F);
        step(1'b0, 1'b1, 1'b1, 1'b0, 7'h06);
        idle(2);

        // Normal frame
        step(1'b1, 1'b1, 1'b0, 1'b1, 7'h3F);
        step(1'b1, 1'b1, 1'b1, 1'b0, 7'h06);

        // Orphan ch1
        step(1'b1, 1'b1, 1'b1, 1'b0, 7'h5B);

        // Timeout, then orphan ch1
        step(1'b1, 1'b1, 1'b0, 1'b1, 7'h4F);
        idle(16);
        step(1'b1, 1'b1, 1'b1, 1'b0, 7'h66);

        // ch1 exactly on the timeout cycle
        step(1'b1, 1'b1, 1'b0, 1'b1, 7'h6D);
        idle(15);
        step(1'b1, 1'b1, 1'b1, 1'b0, 7'h7D);
        idle(1);

        // Double ch0+sync restarts, then ch1 completes
        step(1'b1, 1'b1, 1'b0, 1'b1, 7'h07);
        step(1'b1, 1'b1, 1'b0, 1'b1, 7'h7F);
        idle(3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 7'h6F);

        // ch0 without sync: stored, no error in IDLE, error in GOT0
        step(1'b1, 1'b1, 1'b0, 1'b0, 7'h77);
        step(1'b1, 1'b1, 1'b0, 1'b1, 7'h7C);
        step(1'b1, 1'b1, 1'b0, 1'b0, 7'h39);
        step(1'b1, 1'b1, 1'b1, 1'b1, 7'h5E);

        // Mid-frame reset discards frame silently; later ch1 is an orphan
        step(1'b1, 1'b1, 1'b0, 1'b1, 7'h79);
        step(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 7'h71);

        // Counter wrap and saturation from a clean reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 7'($urandom));
            step(1'b1, 1'b1, 1'b1, 1'b0, 7'($urandom));
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'($urandom), 7'($urandom));
        idle(2);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tdm_demux_7bits.md
Name: tdm_demux_7bits

Overview:
Receive-side counterpart of the 2:1 7-bit segment mux. It takes one shared 7-bit bus that carries two time-multiplexed channels, each word tagged by a select bit. It steers each word into a registered per-channel holding register and tracks frame order (ch0 then ch1) with a small FSM. It sits between the shared display bus and the two LCD/7-segment digit drivers, and it flags framing errors.

Parameters:
W, 7, data width of bus and channel registers
TIMEOUT, 16, max cycles allowed from a frame's ch0 word to its ch1 word (>=2)
CNT_W, 8, width of frame and error counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
bus_in  input  W  time-multiplexed data word
bus_valid  input  1  bus_in is valid this cycle
sel  input  1  channel tag: 0 = ch0, 1 = ch1
sync  input  1  frame start marker, meaningful only with bus_valid
ch0_data  output  W  last ch0 word, held
ch1_data  output  W  last ch1 word, held
ch0_new  output  1  one-cycle pulse: ch0_data updated this cycle
ch1_new  output  1  one-cycle pulse: ch1_data updated this cycle
frame_done  output  1  one-cycle pulse: complete ch0→ch1 frame received
seq_err  output  1  one-cycle pulse: framing error detected
frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W
err_cnt  output  CNT_W  framing errors, saturates at all-ones

Behaviour:
- Reset: clk with rst_n=0 clears all outputs and counters to 0, clears the timer, and sets the FSM to IDLE. Reset mid-frame discards the frame silently (no seq_err).
- Steering is independent of the FSM. On every bus_valid, bus_in is written to ch{sel}_data and ch{sel}_new pulses, both visible the cycle after the input (1-cycle latency). Without bus_valid, data holds and the new-pulses are 0.
- FSM states: IDLE, GOT0.
- IDLE, bus_valid & sel=0 & sync → GOT0, timer=0.
- IDLE, bus_valid & sel=0 & !sync → stay IDLE. Data is stored; no error.
- IDLE, bus_valid & sel=1 (sync ignored) → orphan ch1: seq_err, stay IDLE.
- GOT0, bus_valid & sel=1 → frame_done, frame_cnt+1, → IDLE.
- GOT0, bus_valid & sel=0 & sync → seq_err (ch1 missing), restart: stay GOT0, timer=0.
- GOT0, bus_valid & sel=0 & !sync → seq_err, → IDLE.
- GOT0, no bus_valid: timer+1. When the timer reaches TIMEOUT-1 without a word, assert seq_err and → IDLE.
- Simultaneous events:
  - A ch1 word on the timeout cycle completes the frame; no error.
  - frame_done and seq_err are never asserted in the same cycle.
- Counters: err_cnt increments on every seq_err and saturates, with no wrap. frame_cnt wraps to 0 after all-ones.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - state encoding constants: ST_IDLE=0, ST_GOT0=1
  - default W=7, shared with the mux
  - CH0/CH1 select constants
- One sub-module: tdm_timeout_timer.
  - Counter with clear, enable and terminal-count output, parameterised by TIMEOUT.
  - Uses the same clk/rst_n.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with bus activity → all outputs 0. Release → outputs stay 0 until the first bus_valid.
- Normal frame: (7'h3F, sel=0, sync=1), then (7'h06, sel=1) the next cycle → ch0_data=3F with ch0_new, then ch1_data=06 with ch1_new and frame_done. frame_cnt=1, no seq_err.
- Orphan ch1: in IDLE, (7'h5B, sel=1) → ch1_data=5B, ch1_new, seq_err, err_cnt=1, frame_cnt unchanged.
- Timeout: ch0+sync, then idle 15 cycles (TIMEOUT=16) → seq_err one cycle after the timer hits 15, FSM back in IDLE. A later ch1 word raises another seq_err (orphan).
- Boundary:
  - ch1 arriving exactly on the timeout cycle → frame_done, no seq_err.
  - Double ch0+sync → one seq_err, then a ch1 completes the frame.
- Counter wrap/saturation, CNT_W=2:
  - 5 frames → frame_cnt sequence 1,2,3,0,1.
  - 5 errors → err_cnt stops at 3.
